// File: rtl/dct_postfft_rot.sv
`timescale 1ns/1ps
// dct_postfft_rot
// Post-FFT rotation stage of an FFT-based DCT. Each FFT bin X[k] is rotated by
// e^(-j*pi*k/2N) and only the real part is kept:
//   y[k] = Xr*cos(pi*k/2N) + Xi*sin(pi*k/2N)
// Twiddles come from an external 2048-entry quarter-wave ROM with a one-cycle
// read. The datapath is a 3-stage pipeline with streaming valid/ready handshakes.
//
// Ports
//   clk, rst                     clock, asynchronous active-high reset
//   sink_valid/ready/sop/eop     input handshake and frame markers
//   sink_error                   upstream error code, forwarded with the sample
//   sink_real/imag               FFT bin X[k], natural order
//   fftpts_in/out                frame length N (64..2048); out is a pass-through
//   rom_addr, rom_cos/sin        twiddle ROM address and returned twiddle pair
//   source_valid/ready/sop/eop   output handshake and frame markers
//   source_error                 01 = restart sop, 10 = early eop, else sink_error
//   source_real                  DCT coefficient y[k]
module dct_postfft_rot #(
  parameter int wDataInOut = 16,
  parameter int wTw        = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  sink_valid,
  output logic                  sink_ready,
  input  logic [1:0]            sink_error,
  input  logic                  sink_sop,
  input  logic                  sink_eop,
  input  logic [wDataInOut-1:0] sink_real,
  input  logic [wDataInOut-1:0] sink_imag,
  input  logic [11:0]           fftpts_in,
  output logic [10:0]           rom_addr,
  input  logic [wTw-1:0]        rom_cos,
  input  logic [wTw-1:0]        rom_sin,
  output logic                  source_valid,
  input  logic                  source_ready,
  output logic                  source_sop,
  output logic                  source_eop,
  output logic [1:0]            source_error,
  output logic [wDataInOut-1:0] source_real,
  output logic [11:0]           fftpts_out
);

  localparam int WM = (wDataInOut > wTw) ? wDataInOut : wTw;
  localparam int WP = 2 * WM;
  localparam logic signed [WP:0] MAXV = (WP+1)'(2**(wDataInOut-1) - 1);
  localparam logic signed [WP:0] MINV = -MAXV - (WP+1)'(1);
  localparam logic signed [WP:0] RND  = (WP+1)'(2**(wTw-2));

  localparam logic [0:0] IDLE  = 1'b0;
  localparam logic [0:0] FRAME = 1'b1;

  // Frame tracking
  logic [0:0]  state_q, state_d;
  logic [10:0] k_q, k_d;
  logic [10:0] nm1_q, nm1_d;       // N-1 latched at sop
  logic [3:0]  shift_q, shift_d;   // 11 - log2(N) latched at sop
  logic [10:0] rom_addr_q, rom_addr_d;

  // Stage 1
  logic                         s1_valid_q, s1_valid_d, s1_sop_q, s1_sop_d, s1_eop_q, s1_eop_d;
  logic [1:0]                   s1_err_q, s1_err_d;
  logic signed [wDataInOut-1:0] s1_real_q, s1_real_d, s1_imag_q, s1_imag_d;
  // Stage 2
  logic                         s2_valid_q, s2_valid_d, s2_sop_q, s2_sop_d, s2_eop_q, s2_eop_d;
  logic [1:0]                   s2_err_q, s2_err_d;
  logic signed [WP-1:0]         s2_pc_q, s2_pc_d, s2_ps_q, s2_ps_d;
  // Stage 3
  logic                         s3_valid_q, s3_valid_d, s3_sop_q, s3_sop_d, s3_eop_q, s3_eop_d;
  logic [1:0]                   s3_err_q, s3_err_d;
  logic [wDataInOut-1:0]        s3_real_q, s3_real_d;

  logic        en, accept, keep;
  logic [10:0] k_use, nm1_use, nm1_in;
  logic [3:0]  shift_use, shift_in;
  logic signed [WP-1:0] a_re, a_im, tw_c, tw_s;
  logic signed [WP:0]   sum, shifted;

  // Whole pipeline advances only when the output slot is free or being taken.
  assign en         = source_ready | ~s3_valid_q;
  assign sink_ready = en;
  assign accept     = sink_valid & en & ~rst;
  // The ROM registers its address, so the address for the incoming sample is
  // presented in the same cycle it is accepted; the twiddle then lines up with S1.
  assign rom_addr   = rom_addr_d;
  assign fftpts_out = fftpts_in;

  always_comb begin : frame_ctrl
    // NOTE: every signal gets a default first so no path leaves it unassigned;
    // an unassigned path in always_comb would infer a latch.
    state_d    = state_q;
    k_d        = k_q;
    nm1_d      = nm1_q;
    shift_d    = shift_q;
    rom_addr_d = rom_addr_q;
    s1_valid_d = s1_valid_q;
    s1_sop_d   = s1_sop_q;
    s1_eop_d   = s1_eop_q;
    s1_err_d   = s1_err_q;
    s1_real_d  = s1_real_q;
    s1_imag_d  = s1_imag_q;

    case (fftpts_in)
      12'd64:   shift_in = 4'd5;
      12'd128:  shift_in = 4'd4;
      12'd256:  shift_in = 4'd3;
      12'd512:  shift_in = 4'd2;
      12'd1024: shift_in = 4'd1;
      default:  shift_in = 4'd0;
    endcase
    nm1_in = 11'(fftpts_in - 12'd1);

    // A sop forces k=0 and takes the new frame length for this very sample.
    k_use     = sink_sop ? 11'd0   : k_q;
    nm1_use   = sink_sop ? nm1_in  : nm1_q;
    shift_use = sink_sop ? shift_in : shift_q;
    // Outside a frame only a sop opens one; anything else is dropped.
    keep      = accept & (sink_sop | (state_q == FRAME));

    if (en) begin
      s1_valid_d = keep;
      s1_sop_d   = keep & sink_sop;
      s1_eop_d   = keep & sink_eop;
      s1_real_d  = signed'(sink_real);
      s1_imag_d  = signed'(sink_imag);
      if (!keep)
        s1_err_d = 2'b00;
      else if (sink_sop && (state_q == FRAME))
        s1_err_d = 2'b01;
      else if (sink_eop && (k_use != nm1_use))
        s1_err_d = 2'b10;
      else
        s1_err_d = sink_error;
    end

    if (keep) begin
      rom_addr_d = k_use << shift_use;
      state_d    = sink_eop ? IDLE : FRAME;
      k_d        = (sink_eop || (k_use == nm1_use)) ? 11'd0 : 11'(k_use + 11'd1);
      if (sink_sop) begin
        nm1_d   = nm1_in;
        shift_d = shift_in;
      end
    end
  end

  always_comb begin : datapath
    s2_valid_d = s2_valid_q;
    s2_sop_d   = s2_sop_q;
    s2_eop_d   = s2_eop_q;
    s2_err_d   = s2_err_q;
    s2_pc_d    = s2_pc_q;
    s2_ps_d    = s2_ps_q;
    s3_valid_d = s3_valid_q;
    s3_sop_d   = s3_sop_q;
    s3_eop_d   = s3_eop_q;
    s3_err_d   = s3_err_q;
    s3_real_d  = s3_real_q;

    a_re = WP'(s1_real_q);
    a_im = WP'(s1_imag_q);
    tw_c = WP'(signed'(rom_cos));
    tw_s = WP'(signed'(rom_sin));

    // Round half-up at bit wTw-2, then drop the wTw-1 fraction bits.
    sum     = (WP+1)'(s2_pc_q) + (WP+1)'(s2_ps_q) + RND;
    shifted = sum >>> (wTw - 1);

    if (en) begin
      s2_valid_d = s1_valid_q;
      s2_sop_d   = s1_sop_q;
      s2_eop_d   = s1_eop_q;
      s2_err_d   = s1_err_q;
      s2_pc_d    = a_re * tw_c;
      s2_ps_d    = a_im * tw_s;

      s3_valid_d = s2_valid_q;
      s3_sop_d   = s2_sop_q;
      s3_eop_d   = s2_eop_q;
      s3_err_d   = s2_err_q;
      if (shifted > MAXV)
        s3_real_d = MAXV[wDataInOut-1:0];
      else if (shifted < MINV)
        s3_real_d = MINV[wDataInOut-1:0];
      else
        s3_real_d = shifted[wDataInOut-1:0];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      k_q        <= '0;
      nm1_q      <= '0;
      shift_q    <= '0;
      rom_addr_q <= '0;
      s1_valid_q <= 1'b0;
      s1_sop_q   <= 1'b0;
      s1_eop_q   <= 1'b0;
      s1_err_q   <= '0;
      s1_real_q  <= '0;
      s1_imag_q  <= '0;
      s2_valid_q <= 1'b0;
      s2_sop_q   <= 1'b0;
      s2_eop_q   <= 1'b0;
      s2_err_q   <= '0;
      s2_pc_q    <= '0;
      s2_ps_q    <= '0;
      s3_valid_q <= 1'b0;
      s3_sop_q   <= 1'b0;
      s3_eop_q   <= 1'b0;
      s3_err_q   <= '0;
      s3_real_q  <= '0;
    end else begin
      // NOTE: non-blocking assignments so every stage samples the previous
      // stage's value from before this edge, independent of statement order.
      state_q    <= state_d;
      k_q        <= k_d;
      nm1_q      <= nm1_d;
      shift_q    <= shift_d;
      rom_addr_q <= rom_addr_d;
      s1_valid_q <= s1_valid_d;
      s1_sop_q   <= s1_sop_d;
      s1_eop_q   <= s1_eop_d;
      s1_err_q   <= s1_err_d;
      s1_real_q  <= s1_real_d;
      s1_imag_q  <= s1_imag_d;
      s2_valid_q <= s2_valid_d;
      s2_sop_q   <= s2_sop_d;
      s2_eop_q   <= s2_eop_d;
      s2_err_q   <= s2_err_d;
      s2_pc_q    <= s2_pc_d;
      s2_ps_q    <= s2_ps_d;
      s3_valid_q <= s3_valid_d;
      s3_sop_q   <= s3_sop_d;
      s3_eop_q   <= s3_eop_d;
      s3_err_q   <= s3_err_d;
      s3_real_q  <= s3_real_d;
    end
  end

  assign source_valid = s3_valid_q;
  assign source_sop   = s3_sop_q;
  assign source_eop   = s3_eop_q;
  assign source_error = s3_err_q;
  assign source_real  = s3_real_q;

endmodule

// File: tb/tb_dct_postfft_rot.sv
`timescale 1ns/1ps
// Self-checking bench for dct_postfft_rot: directed frames plus randomized data,
// compared against a behavioural model that works from angles and integer math.
module tb_dct_postfft_rot;

  logic        clk = 1'b0;
  logic        rst;
  logic        sink_valid, sink_ready, sink_sop, sink_eop;
  logic [1:0]  sink_error;
  logic [15:0] sink_real, sink_imag;
  logic [11:0] fftpts_in, fftpts_out;
  logic [10:0] rom_addr;
  logic [15:0] rom_cos, rom_sin;
  logic        source_valid, source_ready, source_sop, source_eop;
  logic [1:0]  source_error;
  logic [15:0] source_real;

  always #5 clk = ~clk;

  dct_postfft_rot #(.wDataInOut(16), .wTw(16)) dut (
    .clk(clk), .rst(rst),
    .sink_valid(sink_valid), .sink_ready(sink_ready), .sink_error(sink_error),
    .sink_sop(sink_sop), .sink_eop(sink_eop),
    .sink_real(sink_real), .sink_imag(sink_imag),
    .fftpts_in(fftpts_in), .rom_addr(rom_addr), .rom_cos(rom_cos), .rom_sin(rom_sin),
    .source_valid(source_valid), .source_ready(source_ready),
    .source_sop(source_sop), .source_eop(source_eop),
    .source_error(source_error), .source_real(source_real), .fftpts_out(fftpts_out)
  );

  // Twiddle ROM: entry i = (cos, sin)(pi*i/4096) in Q1.15, one-cycle read.
  int rom_c [2048];
  int rom_s [2048];
  initial begin
    for (int i = 0; i < 2048; i++) begin
      real a, c, s;
      a = 3.14159265358979323846 * i / 4096.0;
      c = $floor($cos(a) * 32768.0 + 0.5);
      s = $floor($sin(a) * 32768.0 + 0.5);
      rom_c[i] = (c > 32767.0) ? 32767 : $rtoi(c);
      rom_s[i] = (s > 32767.0) ? 32767 : $rtoi(s);
    end
  end
  always @(posedge clk) begin
    rom_cos <= 16'(rom_c[rom_addr]);
    rom_sin <= 16'(rom_s[rom_addr]);
  end

  // Counters and check
  int n_assert = 0;
  int n_fail   = 0;
  task automatic check(input string tag, input longint obs, input longint exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Cycle counter and downstream ready pattern
  int cyc = 0;
  int ready_mode = 0;   // 0: always ready, 1: toggle 1010..., 2: random
  bit tog = 1'b0;
  always @(posedge clk) cyc++;
  always @(negedge clk) begin
    case (ready_mode)
      1:       begin tog = ~tog; source_ready = tog; end
      2:       source_ready = ($urandom_range(0, 3) != 0);
      default: source_ready = 1'b1;
    endcase
  end

  // Output monitor: record {err, sop, eop, y} for every completed handshake.
  logic [19:0] got_q[$];
  int          got_cyc[$];
  logic [19:0] last[$];
  int          last_cyc[$];
  bit          stall_chk = 1'b0;
  always @(negedge clk) begin
    #2;
    if (source_valid === 1'b1 && source_ready === 1'b1) begin
      got_q.push_back({source_error, source_sop, source_eop, source_real});
      got_cyc.push_back(cyc);
    end
    if (stall_chk) check("sink_ready_vs_stall", sink_ready, !(source_valid && !source_ready));
  end

  // Behavioural reference model
  logic [19:0] exp_q[$];
  bit m_in = 1'b0;
  int m_k  = 0;
  int m_n  = 64;

  task automatic model_push(input int xr, input int xi, input bit sop, input bit eop,
                            input bit [1:0] err, output bit kept, output int addr);
    bit     restart;
    int     idx, y;
    longint acc;
    logic [1:0] e;
    restart = 1'b0;
    kept    = 1'b0;
    addr    = 0;
    if (sop) begin
      restart = m_in;
      m_in    = 1'b1;
      m_k     = 0;
      m_n     = int'(fftpts_in);
    end else if (!m_in) begin
      return;
    end
    kept = 1'b1;
    idx  = m_k * (2048 / m_n);
    addr = idx;
    acc  = longint'(xr) * rom_c[idx] + longint'(xi) * rom_s[idx] + 16384;
    acc  = acc >>> 15;
    if (acc > 32767)       y = 32767;
    else if (acc < -32768) y = -32768;
    else                   y = int'(acc);
    if (restart)                    e = 2'b01;
    else if (eop && m_k != m_n - 1) e = 2'b10;
    else                            e = err;
    exp_q.push_back({e, sop, eop, 16'(y)});
    if (eop) begin
      m_in = 1'b0;
      m_k  = 0;
    end else begin
      m_k = (m_k + 1) % m_n;
    end
  endtask

  function automatic int yv(input logic [19:0] r);
    return int'($signed(r[15:0]));
  endfunction

  // Stimulus helpers
  int dr [2048];
  int di [2048];
  int in_sop_cyc = 0;

  function automatic int rnd16();
    return int'($urandom_range(0, 65535)) - 32768;
  endfunction

  task automatic send(input int xr, input int xi, input bit sop, input bit eop, input bit [1:0] err);
    bit kept;
    int addr, guard;
    @(negedge clk);
    sink_valid = 1'b1;
    sink_real  = 16'(xr);
    sink_imag  = 16'(xi);
    sink_sop   = sop;
    sink_eop   = eop;
    sink_error = err;
    #1;
    guard = 0;
    while (!sink_ready && guard <= 200) begin
      @(negedge clk);
      #1;
      guard++;
    end
    if (guard > 200) check("sink_ready_timeout", 0, 1);
    if (sop) in_sop_cyc = cyc;
    model_push(xr, xi, sop, eop, err, kept, addr);
    if (kept) check("rom_addr", rom_addr, addr);
    @(posedge clk);
  endtask

  task automatic send_frame(input int n, input int len, input bit with_eop,
                            input bit rnd_err, input int chg_at);
    fftpts_in = 12'(n);
    for (int i = 0; i < len; i++) begin
      if (i == chg_at) fftpts_in = 12'((n >= 1024) ? 64 : n * 2);
      send(dr[i], di[i], i == 0, with_eop && (i == len - 1),
           rnd_err ? 2'($urandom_range(0, 3)) : 2'b00);
    end
  endtask

  task automatic drain(input string tag);
    int guard;
    @(negedge clk);
    sink_valid = 1'b0;
    sink_sop   = 1'b0;
    sink_eop   = 1'b0;
    guard = 0;
    while (got_q.size() < exp_q.size() && guard < 5000) begin
      @(negedge clk);
      guard++;
    end
    repeat (8) @(negedge clk);
    check({tag, "_count"}, got_q.size(), exp_q.size());
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++)
      check($sformatf("%s[%0d]", tag, i), got_q[i], exp_q[i]);
    last     = got_q;
    last_cyc = got_cyc;
    got_q.delete();
    got_cyc.delete();
    exp_q.delete();
  endtask

  task automatic fill_const(input int xr, input int xi);
    for (int i = 0; i < 2048; i++) begin
      dr[i] = xr;
      di[i] = xi;
    end
  endtask

  task automatic fill_rand();
    for (int i = 0; i < 2048; i++) begin
      dr[i] = rnd16();
      di[i] = rnd16();
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [19:0] ref_q[$];

    // Reset, with a valid sop presented that must not be taken.
    rst          = 1'b1;
    source_ready = 1'b1;
    sink_valid   = 1'b1;
    sink_sop     = 1'b1;
    sink_eop     = 1'b0;
    sink_error   = 2'b00;
    sink_real    = 16'd100;
    sink_imag    = 16'd0;
    fftpts_in    = 12'd64;
    repeat (3) @(negedge clk);
    #1;
    check("rst_source_valid", source_valid, 0);
    check("rst_source_sop",   source_sop,   0);
    check("rst_source_eop",   source_eop,   0);
    check("rst_source_error", source_error, 0);
    check("rst_source_real",  source_real,  0);
    check("rst_rom_addr",     rom_addr,     0);
    check("rst_sink_ready",   sink_ready,   1);
    check("fftpts_out",       fftpts_out,   64);
    @(negedge clk);
    sink_valid = 1'b0;
    sink_sop   = 1'b0;
    rst        = 1'b0;
    repeat (8) @(negedge clk);
    check("no_accept_in_reset", got_q.size(), 0);

    // N=64, X=(16384,0)
    fill_const(16384, 0);
    send_frame(64, 64, 1'b1, 1'b0, -1);
    drain("n64_const");
    if (last.size() == 64) begin
      check("n64_y0",        yv(last[0]), 16384);
      check("n64_y32",       yv(last[32]), 11585);
      check("n64_sop0",      last[0][17], 1);
      check("n64_eop63",     last[63][16], 1);
      check("n64_sop_lat",   last_cyc[0] - in_sop_cyc, 3);
      check("n64_eop_delta", last_cyc[63] - last_cyc[0], 63);
    end

    // N=2048, X=(0,32767)
    fill_const(0, 32767);
    send_frame(2048, 2048, 1'b1, 1'b0, -1);
    drain("n2048");
    if (last.size() == 2048) begin
      check("n2048_y0",        yv(last[0]), 0);
      check("n2048_y2047_1lsb", (yv(last[2047]) >= 32766 && yv(last[2047]) <= 32767), 1);
    end

    // Saturation at k=N/2
    fill_rand();
    dr[32] = 32767;
    di[32] = 32767;
    send_frame(64, 64, 1'b1, 1'b0, -1);
    drain("sat_pos");
    if (last.size() == 64) check("sat_pos_y32", yv(last[32]), 32767);
    dr[32] = -32768;
    di[32] = -32768;
    send_frame(64, 64, 1'b1, 1'b0, -1);
    drain("sat_neg");
    if (last.size() == 64) check("sat_neg_y32", yv(last[32]), -32768);

    // Backpressure: same 256-point frame with ready=1, then ready toggling.
    fill_rand();
    send_frame(256, 256, 1'b1, 1'b0, -1);
    drain("n256_ready");
    ref_q = last;
    ready_mode = 1;
    stall_chk  = 1'b1;
    send_frame(256, 256, 1'b1, 1'b0, -1);
    drain("n256_toggle");
    stall_chk  = 1'b0;
    ready_mode = 0;
    check("toggle_same_count", last.size(), ref_q.size());
    for (int i = 0; i < last.size() && i < ref_q.size(); i++)
      check($sformatf("toggle_vs_ready[%0d]", i), last[i], ref_q[i]);

    // Early eop at k=40, then a clean frame.
    fill_rand();
    send_frame(64, 41, 1'b1, 1'b0, -1);
    send_frame(64, 64, 1'b1, 1'b0, -1);
    drain("early_eop");
    if (last.size() == 105) begin
      check("early_eop_err", last[40][19:18], 2);
      check("early_eop_eop", last[40][16], 1);
      check("next_sop",      last[41][17], 1);
      check("next_sop_err",  last[41][19:18], 0);
    end

    // Dropped samples in IDLE, sop-in-frame restart, single-sample frame.
    for (int i = 0; i < 5; i++) send(rnd16(), rnd16(), 1'b0, 1'b0, 2'b00);
    send_frame(64, 10, 1'b0, 1'b0, -1);
    send_frame(64, 64, 1'b1, 1'b0, -1);
    fftpts_in = 12'd64;
    send(1000, 2000, 1'b1, 1'b1, 2'b00);
    drain("restart");
    if (last.size() == 75) begin
      check("restart_err",   last[10][19:18], 1);
      check("restart_sop",   last[10][17], 1);
      check("single_err",    last[74][19:18], 2);
      check("single_soeop",  last[74][17:16], 3);
    end

    // Reset mid-frame at k=20.
    fill_rand();
    send_frame(64, 20, 1'b0, 1'b0, -1);
    @(negedge clk);
    sink_valid = 1'b0;
    rst        = 1'b1;
    #1;
    check("midrst_valid",    source_valid, 0);
    check("midrst_rom_addr", rom_addr, 0);
    check("midrst_ready",    sink_ready, 1);
    repeat (2) @(negedge clk);
    got_q.delete();
    got_cyc.delete();
    exp_q.delete();
    m_in = 1'b0;
    m_k  = 0;
    rst  = 1'b0;
    repeat (10) @(negedge clk);
    check("no_stale_out", got_q.size(), 0);
    for (int i = 0; i < 3; i++) send(rnd16(), rnd16(), 1'b0, 1'b0, 2'b00);
    send_frame(64, 64, 1'b1, 1'b0, -1);
    drain("post_rst");
    if (last.size() == 64) begin
      check("post_rst_first_sop", last[0][17], 1);
      check("post_rst_first_err", last[0][19:18], 0);
    end

    // Random frames, random ready, random sink_error, mid-frame fftpts change.
    ready_mode = 2;
    for (int f = 0; f < 3; f++) begin
      int n;
      n = 64 << $urandom_range(0, 2);
      fill_rand();
      send_frame(n, n, 1'b1, 1'b1, (f == 1) ? n / 2 : -1);
      drain($sformatf("rand%0d", f));
    end
    ready_mode = 0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
